hif_window_sequencer: RTL and testbench

Controller for the high-frequency circular sample queue (dual-port 1536x16 RAM). It owns the queue's write and read pointers and tracks how full the queue is. On every new sample, once the queue holds a full window, it sequences one pass over the NTAPS most recent samples: it drives RAM read addresses and coefficient-ROM addresses, and sends clear/accumulate/valid strobes to the shared MAC. Sits between the sample-rate strobe logic and the RAM + coefficient ROM + MAC datapath.

---
 rtl/hif_window_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_hif_window_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hif_window_sequencer.sv
// ---------------------------------------------------------------------------
// hif_window_sequencer
//   Controller for the high-frequency circular sample queue. It owns the
//   queue write/read pointers and the fill count. Once the queue holds a
//   full window, each new sample launches one pass over the NTAPS most
//   recent samples. A pass drives RAM/ROM read addresses and MAC strobes.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   wrt_smpl     : one-clk strobe, new sample on RAM wdata this cycle
//   flush        : synchronous clear of queue state, aborts any pass
//   we, waddr    : RAM write port (combinational from wrt_smpl / new_ptr)
//   raddr, caddr : RAM read / coefficient ROM addresses (registered)
//   clr_acc      : MAC loads the product instead of accumulating (first tap)
//   acc_en       : MAC product valid this cycle
//   rslt_vld     : one-clk pulse, MAC result complete
//   sequencing   : pass in progress
//   full         : queue holds NTAPS valid samples
//   ovr_err      : sticky, a trigger arrived while a pass was busy
// ---------------------------------------------------------------------------
module hif_window_sequencer #(
  parameter int DEPTH = 1536,
  parameter int NTAPS = 1021,
  parameter int AW    = 11,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wrt_smpl,
  input  logic          flush,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic [CW-1:0] caddr,
  output logic          clr_acc,
  output logic          acc_en,
  output logic          rslt_vld,
  output logic          sequencing,
  output logic          full,
  output logic          ovr_err
);

  localparam int CNTW = $clog2(NTAPS + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     new_ptr_q, new_ptr_d;
  logic [AW-1:0]     old_ptr_q, old_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ovr_q, ovr_d;
  logic              clr_q, clr_d;
  logic              acc_q, acc_d;
  logic              rv_q, rv_d;
  logic              seq_q, seq_d;
  logic              busy, trig;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    clr_d     = 1'b0;
    acc_d     = 1'b0;
    rv_d      = 1'b0;
    seq_d     = 1'b0;

    busy = (state_q == READ) || (state_q == DRAIN);

    // Queue bookkeeping: the oldest pointer only moves once the window is full,
    // so a new write then evicts exactly one sample from the window.
    if (wrt_smpl) begin
      new_ptr_d = ptr_inc(new_ptr_q);
      if (cnt_q == CNTW'(NTAPS)) old_ptr_d = ptr_inc(old_ptr_q);
      else                       cnt_d     = cnt_q + CNTW'(1);
    end

    trig = wrt_smpl && (cnt_d == CNTW'(NTAPS)) &&
           ((state_q == IDLE) || (state_q == DONE));

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d  = READ;
          rd_ptr_d = old_ptr_d;   // post-update: tap 0 pairs with oldest sample
          k_d      = '0;
        end
      end
      READ: begin
        // Data for the address issued now returns next cycle.
        acc_d = 1'b1;
        clr_d = (k_q == '0);
        if (k_q == CW'(NTAPS - 1)) begin
          state_d = DRAIN;        // hold last raddr/caddr
        end else begin
          rd_ptr_d = ptr_inc(rd_ptr_q);
          k_d      = k_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (trig) begin
          state_d  = READ;
          rd_ptr_d = old_ptr_d;
          k_d      = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // rd_ptr is separate from old_ptr, so the write still lands and the
    // in-flight pass is unaffected; only the new trigger is lost.
    if (wrt_smpl && busy) ovr_d = 1'b1;

    rv_d  = (state_q == DRAIN);
    seq_d = (state_d == READ) || (state_d == DRAIN);

    if (flush) begin
      state_d   = IDLE;
      new_ptr_d = '0;
      old_ptr_d = '0;
      rd_ptr_d  = '0;
      k_d       = '0;
      cnt_d     = '0;
      ovr_d     = 1'b0;
      clr_d     = 1'b0;
      acc_d     = 1'b0;
      rv_d      = 1'b0;
      seq_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      clr_q     <= 1'b0;
      acc_q     <= 1'b0;
      rv_q      <= 1'b0;
      seq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      clr_q     <= clr_d;
      acc_q     <= acc_d;
      rv_q      <= rv_d;
      seq_q     <= seq_d;
    end
  end

  assign we         = wrt_smpl;
  assign waddr      = new_ptr_q;
  assign raddr      = rd_ptr_q;
  assign caddr      = k_q;
  assign clr_acc    = clr_q;
  assign acc_en     = acc_q;
  assign rslt_vld   = rv_q;
  assign sequencing = seq_q;
  assign full       = (cnt_q == CNTW'(NTAPS));
  assign ovr_err    = ovr_q;

endmodule

// File: tb/tb_hif_window_sequencer.sv
module tb_hif_window_sequencer;

  localparam int DP = 8;
  localparam int NT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // small instance
  logic s_wrt = 1'b0, s_flush = 1'b0;
  logic s_we, s_clr, s_acc, s_rv, s_seq, s_full, s_ovr;
  logic [2:0] s_waddr, s_raddr;
  logic [1:0] s_caddr;

  // default-size instance
  logic b_wrt = 1'b0, b_flush = 1'b0;
  logic b_we, b_clr, b_acc, b_rv, b_seq, b_full, b_ovr;
  logic [10:0] b_waddr, b_raddr;
  logic [9:0]  b_caddr;

  hif_window_sequencer #(.DEPTH(DP), .NTAPS(NT), .AW(3), .CW(2)) u_small (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(s_wrt), .flush(s_flush),
    .we(s_we), .waddr(s_waddr), .raddr(s_raddr), .caddr(s_caddr),
    .clr_acc(s_clr), .acc_en(s_acc), .rslt_vld(s_rv), .sequencing(s_seq),
    .full(s_full), .ovr_err(s_ovr));

  hif_window_sequencer u_big (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(b_wrt), .flush(b_flush),
    .we(b_we), .waddr(b_waddr), .raddr(b_raddr), .caddr(b_caddr),
    .clr_acc(b_clr), .acc_en(b_acc), .rslt_vld(b_rv), .sequencing(b_seq),
    .full(b_full), .ovr_err(b_ovr));

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic wrt, flush, we;
    int   waddr, raddr, caddr;
    logic clr, acc, rv, seq, full, ovr, chka;
  } vec_t;

  vec_t tbl [18];

  // behavioural model state: t = cycle index within a pass (0 = no pass)
  int  m_nwr, m_cnt, m_t, m_base, m_ra, m_ca;
  bit  m_ovr, m_known, m_busy;

  initial begin
    // window pass after fill, back-to-back trigger in DONE, overrun, flush
    tbl[0]  = '{1,0,1, 0,0,0, 0,0,0,0,0,0,1};
    tbl[1]  = '{1,0,1, 1,0,0, 0,0,0,0,0,0,1};
    tbl[2]  = '{1,0,1, 2,0,0, 0,0,0,0,0,0,1};
    tbl[3]  = '{1,0,1, 3,0,0, 0,0,0,0,0,0,1};
    tbl[4]  = '{0,0,0, 4,0,0, 0,0,0,1,1,0,1};
    tbl[5]  = '{0,0,0, 4,1,1, 1,1,0,1,1,0,1};
    tbl[6]  = '{0,0,0, 4,2,2, 0,1,0,1,1,0,1};
    tbl[7]  = '{0,0,0, 4,3,3, 0,1,0,1,1,0,1};
    tbl[8]  = '{0,0,0, 4,3,3, 0,1,0,1,1,0,1};
    tbl[9]  = '{1,0,1, 4,3,3, 0,0,1,0,1,0,1};
    tbl[10] = '{0,0,0, 5,1,0, 0,0,0,1,1,0,1};
    tbl[11] = '{1,0,1, 5,2,1, 1,1,0,1,1,0,1};
    tbl[12] = '{0,0,0, 6,3,2, 0,1,0,1,1,1,1};
    tbl[13] = '{0,0,0, 6,4,3, 0,1,0,1,1,1,1};
    tbl[14] = '{0,0,0, 6,4,3, 0,1,0,1,1,1,1};
    tbl[15] = '{0,0,0, 6,4,3, 0,0,1,0,1,1,1};
    tbl[16] = '{0,1,0, 6,4,3, 0,0,0,0,1,1,1};
    tbl[17] = '{0,0,0, 0,0,0, 0,0,0,0,0,0,0};

    // reset state
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_we", s_we, 0);       chk("rst_waddr", s_waddr, 0);
    chk("rst_raddr", s_raddr, 0); chk("rst_caddr", s_caddr, 0);
    chk("rst_acc", s_acc, 0);     chk("rst_clr", s_clr, 0);
    chk("rst_rv", s_rv, 0);       chk("rst_seq", s_seq, 0);
    chk("rst_full", s_full, 0);   chk("rst_ovr", s_ovr, 0);
    @(negedge clk); rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      s_wrt = tbl[i].wrt; s_flush = tbl[i].flush;
      #1;
      chk($sformatf("tbl%0d_we", i), s_we, tbl[i].we);
      chk($sformatf("tbl%0d_waddr", i), s_waddr, tbl[i].waddr);
      if (tbl[i].chka) begin
        chk($sformatf("tbl%0d_raddr", i), s_raddr, tbl[i].raddr);
        chk($sformatf("tbl%0d_caddr", i), s_caddr, tbl[i].caddr);
      end
      chk($sformatf("tbl%0d_clr", i), s_clr, tbl[i].clr);
      chk($sformatf("tbl%0d_acc", i), s_acc, tbl[i].acc);
      chk($sformatf("tbl%0d_rv", i), s_rv, tbl[i].rv);
      chk($sformatf("tbl%0d_seq", i), s_seq, tbl[i].seq);
      chk($sformatf("tbl%0d_full", i), s_full, tbl[i].full);
      chk($sformatf("tbl%0d_ovr", i), s_ovr, tbl[i].ovr);
    end
    s_wrt = 1'b0; s_flush = 1'b0;

    // flush in the 2nd READ cycle: queue empty, pass aborted
    for (int i = 0; i < NT; i++) begin
      @(negedge clk); s_wrt = 1'b1; #1;
      chk("fl_fill_waddr", s_waddr, i);
    end
    @(negedge clk); s_wrt = 1'b0; #1;
    chk("fl_seq_c1", s_seq, 1);
    @(negedge clk); s_flush = 1'b1; #1;
    chk("fl_acc_c2", s_acc, 1);
    @(negedge clk); s_flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fl_acc", s_acc, 0); chk("fl_seq", s_seq, 0); chk("fl_rv", s_rv, 0);
      chk("fl_full", s_full, 0); chk("fl_ovr", s_ovr, 0);
      @(negedge clk);
    end
    s_wrt = 1'b1; #1;
    chk("fl_next_waddr", s_waddr, 0);

    // async reset in the middle of a pass
    for (int i = 0; i < NT - 1; i++) begin
      @(negedge clk); s_wrt = 1'b1;
    end
    @(negedge clk); s_wrt = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("ar_acc_before", s_acc, 1);
    rst_n = 1'b0; #1;
    chk("ar_acc", s_acc, 0); chk("ar_seq", s_seq, 0);
    chk("ar_clr", s_clr, 0); chk("ar_full", s_full, 0);
    @(negedge clk); rst_n = 1'b1;

    // randomized run against the model
    m_nwr = 0; m_cnt = 0; m_t = 0; m_base = 0; m_ra = 0; m_ca = 0;
    m_ovr = 0; m_known = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      s_wrt   = ($urandom_range(0, 2) == 0);
      s_flush = ($urandom_range(0, 149) == 0);
      #1;
      if (m_t >= 1 && m_t <= NT) begin
        m_ra = (m_base + m_t - 1) % DP;
        m_ca = m_t - 1;
      end
      chk("rnd_we", s_we, s_wrt);
      chk("rnd_waddr", s_waddr, m_nwr);
      if (m_known) begin
        chk("rnd_raddr", s_raddr, m_ra);
        chk("rnd_caddr", s_caddr, m_ca);
      end
      chk("rnd_seq", s_seq, (m_t >= 1 && m_t <= NT + 1));
      chk("rnd_acc", s_acc, (m_t >= 2 && m_t <= NT + 1));
      chk("rnd_clr", s_clr, (m_t == 2));
      chk("rnd_rv", s_rv, (m_t == NT + 2));
      chk("rnd_full", s_full, (m_cnt == NT));
      chk("rnd_ovr", s_ovr, m_ovr);
      // advance the model across the coming clock edge
      if (s_flush) begin
        m_nwr = 0; m_cnt = 0; m_t = 0; m_ovr = 0; m_known = 0;
      end else begin
        m_busy = (m_t >= 1 && m_t <= NT + 1);
        if (m_t > 0) m_t = (m_t == NT + 2) ? 0 : m_t + 1;
        if (s_wrt) begin
          m_nwr = (m_nwr + 1) % DP;
          if (m_cnt < NT) m_cnt++;
          if (m_busy) m_ovr = 1;
          else if (m_cnt == NT) begin
            m_t = 1;
            m_base = (m_nwr - NT + DP) % DP;
            m_known = 1;
          end
        end
      end
    end
    @(negedge clk); s_wrt = 1'b0; s_flush = 1'b0;

    // default parameters: full window pass
    begin
      int nacc, bad, rvt;
      nacc = 0; bad = 0; rvt = -1;
      for (int i = 0; i < 1021; i++) begin
        @(negedge clk); b_wrt = 1'b1; #1;
        if (b_waddr != 11'(i)) bad++;
        if (i == 1020) chk("big_full_pre", b_full, 0);
      end
      chk("big_waddr_seq", bad, 0);
      bad = 0;
      for (int t = 1; t <= 1100; t++) begin
        @(negedge clk); b_wrt = 1'b0; #1;
        if (b_acc) nacc++;
        if (t <= 1021 && (b_raddr != 11'(t - 1) || b_caddr != 10'(t - 1))) bad++;
        if (b_rv && rvt < 0) rvt = t;
        if (rvt >= 0 && t > rvt + 2) break;
      end
      chk("big_acc_cycles", nacc, 1021);
      chk("big_raddr_seq", bad, 0);
      chk("big_rv_cycle", rvt, 1023);
      chk("big_full", b_full, 1);
      chk("big_ovr", b_ovr, 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
